// File: rtl/filterbank_mac.sv
// Time-multiplexed NCH-channel FIR bank: one shared circular sample delay line and one MAC per channel.
// The coefficient memories share one address bus, and each output is rounded half-up and saturated to DW bits.
module filterbank_mac #(
    parameter int NCH    = 8,
    parameter int NTAPS  = 64,
    parameter int DW     = 16,
    parameter int CW     = 36,
    parameter int OSHIFT = 34
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DW-1:0]           datain,
    input  logic                    din_enable,
    output logic [$clog2(NTAPS)-1:0] coeffaddress,
    input  logic [NCH*CW-1:0]       coeff,
    output logic [NCH*DW-1:0]       dataout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int AW   = $clog2(NTAPS);
    localparam int ACCW = DW + CW + AW;

    localparam logic signed [ACCW-1:0] ONE      = {{(ACCW-1){1'b0}}, 1'b1};
    localparam logic signed [ACCW-1:0] RND      = ONE <<< (OSHIFT - 1);
    localparam logic signed [ACCW-1:0] SMAX     = (ONE <<< (DW - 1)) - ONE;
    localparam logic signed [ACCW-1:0] SMIN     = -(ONE <<< (DW - 1));
    localparam logic [AW-1:0]          PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]          LAST_TAP = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic                    drain_q, drain_d;
    logic                    tap_v_q, tap_v_d;
    logic signed [DW-1:0]    sample_q, sample_d;
    logic [DW-1:0]           dbuf_q [NTAPS];
    logic [DW-1:0]           dbuf_d [NTAPS];
    logic signed [ACCW-1:0]  acc_q [NCH];
    logic signed [ACCW-1:0]  acc_d [NCH];
    logic [NCH*DW-1:0]       dataout_q, dataout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    accept_s;

    function automatic logic [DW-1:0] round_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] r;
        r = (a + RND) >>> OSHIFT;
        if (r > SMAX) begin
            round_sat = SMAX[DW-1:0];
        end else if (r < SMIN) begin
            round_sat = SMIN[DW-1:0];
        end else begin
            round_sat = r[DW-1:0];
        end
    endfunction

    // Sequencer, delay-line write, tap pipeline and per-channel accumulation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wptr_d       = wptr_q;
        drain_d      = drain_q;
        tap_v_d      = 1'b0;
        sample_d     = dbuf_q[wptr_q - addr_q];
        dbuf_d       = dbuf_q;
        acc_d        = acc_q;
        dataout_d    = dataout_q;
        dout_valid_d = 1'b0;
        overrun_d    = overrun_q;
        // OUT doubles as an accept slot so back-to-back samples sit NTAPS+3 clocks apart.
        accept_s     = din_enable && ((state_q == ST_IDLE) || (state_q == ST_OUT));

        case (state_q)
            ST_IDLE, ST_OUT: begin
                addr_d  = '0;
                drain_d = 1'b0;
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                tap_v_d = 1'b1;
                if (addr_q == LAST_TAP) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + PTR_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d      = ST_OUT;
                    dout_valid_d = 1'b1;
                    for (int c = 0; c < NCH; c++) begin
                        dataout_d[c*DW +: DW] = round_sat(acc_q[c]);
                    end
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The sample fetched with address k meets that address's read data one cycle later.
        if (accept_s) begin
            wptr_d         = wptr_q + PTR_ONE;
            dbuf_d[wptr_d] = datain;
            for (int c = 0; c < NCH; c++) begin
                acc_d[c] = '0;
            end
        end else if (tap_v_q) begin
            for (int c = 0; c < NCH; c++) begin
                acc_d[c] = acc_q[c] + ACCW'($signed(coeff[c*CW +: CW])) * ACCW'(sample_q);
            end
        end else begin
            acc_d = acc_q;
        end

        if (din_enable && !accept_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wptr_q       <= '0;
            drain_q      <= 1'b0;
            tap_v_q      <= 1'b0;
            sample_q     <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                dbuf_q[i] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wptr_q       <= wptr_d;
            drain_q      <= drain_d;
            tap_v_q      <= tap_v_d;
            sample_q     <= sample_d;
            dataout_q    <= dataout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            dbuf_q       <= dbuf_d;
            acc_q        <= acc_d;
        end
    end

    assign coeffaddress = addr_q;
    assign dataout      = dataout_q;
    assign dout_valid   = dout_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_filterbank_mac.sv
// Self-checking bench for filterbank_mac: directed and randomized samples against a convolution model.
// The coefficient memories are modelled here as synchronous-read arrays.
module tb_filterbank_mac;

    localparam int NCH    = 8;
    localparam int NTAPS  = 64;
    localparam int DW     = 16;
    localparam int CW     = 36;
    localparam int OSHIFT = 34;
    localparam int AW     = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [DW-1:0]     datain;
    logic              din_enable;
    logic [AW-1:0]     coeffaddress;
    logic [NCH*CW-1:0] coeff;
    logic [NCH*DW-1:0] dataout;
    logic              dout_valid;
    logic              busy;
    logic              overrun;

    logic signed [CW-1:0] cmem [NCH][NTAPS];
    longint               hist[$];
    int                   n_cmp  = 0;
    int                   n_fail = 0;
    bit                   ovr_exp;

    filterbank_mac #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OSHIFT(OSHIFT)) dut (
        .clock        (clock),
        .reset        (reset),
        .datain       (datain),
        .din_enable   (din_enable),
        .coeffaddress (coeffaddress),
        .coeff        (coeff),
        .dataout      (dataout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            coeff[c*CW +: CW] <= cmem[c][coeffaddress];
        end
    end

    // y = sum c[k]*x[n-k], then round half up, shift and clamp
    function automatic longint model_out(input int c);
        longint s;
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k < hist.size()) s += longint'(cmem[c][k]) * hist[k];
        end
        s = (s + (longint'(1) <<< (OSHIFT - 1))) >>> OSHIFT;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hist.delete();
        ovr_exp = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == 0) chk("busy_idle", 64'(busy), 64'd0);
        end
    endtask

    // Called at a negedge; returns at the negedge of the dout_valid cycle.
    task automatic run_sample(input logic signed [DW-1:0] x, input int drop_at);
        logic [31:0] r;
        datain     = x;
        din_enable = 1'b1;
        @(negedge clock);
        din_enable = 1'b0;
        hist.push_front(longint'(x));
        while (hist.size() > NTAPS) void'(hist.pop_back());
        chk("busy_e0", 64'(busy), 64'd1);
        chk("addr_e0", 64'(coeffaddress), 64'd0);
        for (int i = 1; i <= NTAPS + 2; i++) begin
            @(negedge clock);
            din_enable = (i == drop_at);
            if (i == drop_at) begin
                r       = $urandom();
                datain  = r[DW-1:0];
                ovr_exp = 1'b1;
            end
            if (i < NTAPS) chk("addr_seq", 64'(coeffaddress), 64'(i));
            if (i <= NTAPS + 1) begin
                chk("valid_early", 64'(dout_valid), 64'd0);
                chk("busy_run", 64'(busy), 64'd1);
            end else begin
                chk("valid_pulse", 64'(dout_valid), 64'd1);
                chk("busy_out", 64'(busy), 64'd1);
                chk("overrun", 64'(overrun), 64'(ovr_exp));
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("dataout%0d", c), 64'($signed(dataout[c*DW +: DW])), model_out(c));
                end
            end
        end
        din_enable = 1'b0;
    endtask

    initial begin
        logic [63:0] t;
        logic [31:0] r;
        bit          seen;
        reset      = 1'b1;
        din_enable = 1'b0;
        datain     = '0;
        ovr_exp    = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) cmem[c][k] = '0;
        repeat (3) @(negedge clock);
        chk("rst_addr", 64'(coeffaddress), 64'd0);
        chk("rst_dataout", 64'(dataout), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // impulse through ramp coefficients: outputs n+1 and -(n+1), then zero
        for (int k = 0; k < NTAPS; k++) begin
            cmem[0][k] = CW'(longint'(k + 1) <<< 20);
            cmem[1][k] = CW'(-(longint'(k + 1) <<< 20));
        end
        run_sample(16'sd16384, 0);
        idle(13);
        chk("impulse_first0", 64'($signed(dataout[DW-1:0])), 64'sd1);
        for (int n = 1; n < NTAPS + 2; n++) begin
            run_sample(16'sd0, 0);
            idle(13);
        end

        // rounding boundaries
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) cmem[c][k] = '0;
        cmem[0][0] = CW'(longint'(1) <<< 33);
        cmem[1][0] = CW'(-(longint'(1) <<< 33));
        cmem[2][0] = CW'((longint'(1) <<< 33) - 1);
        run_sample(16'sd1, 0);
        chk("round_up", 64'($signed(dataout[0 +: DW])), 64'sd1);
        chk("round_neg", 64'($signed(dataout[DW +: DW])), 64'sd0);
        chk("round_below", 64'($signed(dataout[2*DW +: DW])), 64'sd0);
        idle(4);

        // saturation at minimum spacing (back-to-back samples)
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) cmem[c][k] = CW'(longint'(1) <<< 33);
        for (int n = 0; n < NTAPS; n++) run_sample(16'sd32767, 0);
        chk("sat_pos", 64'($signed(dataout[0 +: DW])), 64'sd32767);
        for (int n = 0; n < NTAPS; n++) run_sample(-16'sd32768, 0);
        chk("sat_neg", 64'($signed(dataout[0 +: DW])), -64'sd32768);
        idle(3);

        // random full-range and small coefficients with random samples
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) begin
                t = {$urandom(), $urandom()};
                cmem[c][k] = t[CW-1:0];
            end
        for (int n = 0; n < 8; n++) begin
            r = $urandom();
            run_sample(r[DW-1:0], 0);
            idle(int'($urandom_range(1, 6)));
        end
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) begin
                t = {$urandom(), $urandom()};
                cmem[c][k] = CW'($signed(t[23:0]));
            end
        for (int n = 0; n < 24; n++) begin
            r = $urandom();
            run_sample(r[DW-1:0], 0);
            if (r[16]) idle(2);
        end
        idle(2);

        // overrun: dropped strobes mid-run and one clock short of minimum spacing
        chk("overrun_clear", 64'(overrun), 64'd0);
        r = $urandom();
        run_sample(r[DW-1:0], 9);
        for (int n = 0; n < 3; n++) begin
            r = $urandom();
            run_sample(r[DW-1:0], NTAPS + 1);
        end
        idle(20);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // reset in the middle of a computation
        datain     = 16'h7abc;
        din_enable = 1'b1;
        @(negedge clock);
        din_enable = 1'b0;
        repeat (29) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_addr", 64'(coeffaddress), 64'd0);
        chk("abort_dataout", 64'(dataout), 64'd0);
        chk("abort_valid", 64'(dout_valid), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        hist.delete();
        ovr_exp = 1'b0;
        seen    = 1'b0;
        repeat (80) begin
            @(negedge clock);
            if (dout_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) cmem[c][k] = '0;
        for (int k = 0; k < NTAPS; k++) cmem[0][k] = CW'(longint'(k + 1) <<< 20);
        run_sample(16'sd16384, 0);
        chk("post_abort0", 64'($signed(dataout[0 +: DW])), 64'sd1);
        run_sample(16'sd0, 0);
        chk("post_abort1", 64'($signed(dataout[0 +: DW])), 64'sd2);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
